load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//   Execute-downstream stage. Uses the ALU result as the effective address and runs a
//   multi-cycle load/store handshake on a req/gnt/rvalid data bus. Generates byte strobes,
//   lane-aligns store data, sign/zero-extends load data, and stalls the core until done.
// PARAMETERS
//   ADDR_WIDTH   32   effective address width; matches ALU result width
//   DATA_WIDTH   32   bus and register data width; fixed at 32 for byte-lane logic
// PORTS
//   clk            in   1   rising-edge clock
//   rst            in   1   synchronous, active-high reset
//   lsu_valid      in   1   instruction in execute is a memory op this cycle
//   mem_read       in   1   load
//   mem_write      in   1   store; mem_read and mem_write never both 1
//   funct3         in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr           in   32  effective address (ALU result)
//   store_data     in   32  rs2 value
//   lsu_stall      out  1   hold PC and pipeline
//   lsu_done       out  1   one-cycle pulse: access complete
//   load_data      out  32  extended load result; valid while lsu_done=1
//   bus_req        out  1   bus request
//   bus_we         out  1   1 = write
//   bus_addr       out  32  word-aligned address {addr[31:2],2'b00}
//   bus_wdata      out  32  lane-replicated store data
//   bus_wstrb      out  4   byte enables
//   bus_gnt        in   1   request accepted this cycle
//   bus_rvalid     in   1   read data valid
//   bus_rdata      in   32  read data word
// BEHAVIOUR
//   - Reset values: all outputs 0; state IDLE.
//   - States: IDLE, REQ, WAIT, DONE.
//   - IDLE: on lsu_valid & (mem_read|mem_write), register addr/data/funct3/we and go to REQ.
//     lsu_stall=1 combinationally in this cycle.
//   - REQ: bus_req=1. bus_addr/we/wdata/wstrb held stable until bus_gnt.
//     On gnt: write goes to DONE; read goes to WAIT. A gnt in the first REQ cycle is legal.
//   - WAIT: on bus_rvalid, capture the extracted/extended word into load_data and go to DONE.
//     rvalid arriving in the same cycle as gnt is ignored; rvalid is valid only in WAIT.
//   - DONE: lsu_done=1 and lsu_stall=0 for exactly one cycle, then go to IDLE.
//     lsu_valid in DONE is not restarted; a new op starts from IDLE on the next cycle.
//   - lsu_stall=1 in REQ and WAIT. Minimum latency: store 2 cycles to done, load 3.
//   - Strobes: B = 4'b0001<<addr[1:0]; H = 4'b0011<<{addr[1],1'b0}; W = 4'b1111.
//     Store data is replicated into lanes: B {4{d[7:0]}}, H {2{d[15:0]}}, W d.
//   - Loads select the lane by addr[1:0]. B/H sign-extend; BU/HU zero-extend.
//   - Illegal funct3 (011, 11x, or a store with 1xx): no bus request; go straight to DONE
//     with load_data=0.
//   - Reset mid-operation drops bus_req in the same cycle and returns to IDLE.
//     A late rvalid is ignored.
// CONFIGURATION
//   MISALIGN_TRAP_EN defined:
//     - Output port misalign_trap (1 bit) is present.
//     - A misaligned H (addr[0]) or W (addr[1:0]!=0) makes no bus request.
//     - The FSM goes to DONE with misalign_trap=1 for that cycle and load_data=0.
//   MISALIGN_TRAP_EN undefined:
//     - The port is absent.
//     - Misaligned low address bits are silently forced to natural alignment:
//       H clears addr[0]; W clears addr[1:0].
// STRUCTURE
//   lsu_pkg:
//     - State encoding localparams.
//     - funct3 codes: LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU.
//     - Strobe constants.
//   Sub-module lsu_align (combinational):
//     - Store path: wstrb and wdata generation.
//     - Load path: lane extraction and extension.
//   The FSM and registers stay in load_store_unit.
// TESTING
//   1. SW addr=0x104, d=0xDEADBEEF, gnt after 2 cycles:
//      -> wstrb=1111, bus_addr=0x104, stall for 3 cycles, done pulse.
//   2. SB addr=0x103, d=0x000000A5, gnt immediately:
//      -> wstrb=1000, wdata=0xA5A5A5A5, done on cycle 2.
//   3. LB addr=0x202, rdata=0x12F45678 -> load_data=0xFFFFFFF4.
//      LBU at the same address -> 0x000000F4.
//   4. LH addr=0x202, rdata=0x8001_0000 -> 0xFFFF8001.
//      With MISALIGN_TRAP_EN, LW addr=0x201 -> misaligned, trap=1, no bus_req.
//   5. rst asserted in WAIT -> bus_req=0 and IDLE next cycle.
//      A following rvalid gives no lsu_done.
//   6. funct3=011 load -> no bus_req, done next cycle, load_data=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types, widths, funct3 codes, strobe constants and decode helpers for the load/store unit.
// Build option: define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of force-aligning them.
package lsu_pkg;

   localparam int unsigned ADDR_WIDTH = 32;
   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned F3_WIDTH   = 3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_REQ  = ST_REQ,
      S_WAIT = ST_WAIT,
      S_DONE = ST_DONE
   } lsu_state_e;

   localparam logic [F3_WIDTH-1:0] LSU_B  = 3'b000;
   localparam logic [F3_WIDTH-1:0] LSU_H  = 3'b001;
   localparam logic [F3_WIDTH-1:0] LSU_W  = 3'b010;
   localparam logic [F3_WIDTH-1:0] LSU_BU = 3'b100;
   localparam logic [F3_WIDTH-1:0] LSU_HU = 3'b101;

   localparam logic [STRB_WIDTH-1:0] STRB_B = 4'b0001;
   localparam logic [STRB_WIDTH-1:0] STRB_H = 4'b0011;
   localparam logic [STRB_WIDTH-1:0] STRB_W = 4'b1111;

   // Registered bus request payload held stable while bus_req is up
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic                  we;
      logic [DATA_WIDTH-1:0] wdata;
      logic [STRB_WIDTH-1:0] wstrb;
   } lsu_req_t;

   // Unsigned widths only exist for loads
   function automatic logic f3_legal(input logic [F3_WIDTH-1:0] f3, input logic we);
      case (f3)
         LSU_B, LSU_H, LSU_W: return 1'b1;
         LSU_BU, LSU_HU:      return ~we;
         default:             return 1'b0;
      endcase
   endfunction

   function automatic logic f3_misaligned(input logic [F3_WIDTH-1:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b01:   return off[0];
         2'b10:   return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] f3_align(input logic [F3_WIDTH-1:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b01:   return {off[1], 1'b0};
         2'b10:   return 2'b00;
         default: return off;
      endcase
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-bus interface between the load/store unit (master) and memory (slave).
interface lsu_if;
   import lsu_pkg::*;

   logic                  bus_req;
   logic                  bus_we;
   logic [ADDR_WIDTH-1:0] bus_addr;
   logic [DATA_WIDTH-1:0] bus_wdata;
   logic [STRB_WIDTH-1:0] bus_wstrb;
   logic                  bus_gnt;
   logic                  bus_rvalid;
   logic [DATA_WIDTH-1:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      input  bus_gnt, bus_rvalid, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      output bus_gnt, bus_rvalid, bus_rdata
   );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store strobe/data replication and load lane extraction/extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [F3_WIDTH-1:0]   st_funct3,
   input  logic [1:0]            st_off,
   input  logic [DATA_WIDTH-1:0] st_data,
   output logic [STRB_WIDTH-1:0] wstrb,
   output logic [DATA_WIDTH-1:0] wdata,
   input  logic [F3_WIDTH-1:0]   ld_funct3,
   input  logic [1:0]            ld_off,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic [DATA_WIDTH-1:0] ld_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Store path: strobes follow the offset, data is replicated across every lane
   always_comb begin
      wstrb = '0;
      wdata = '0;
      case (st_funct3)
         LSU_B: begin
            wstrb = STRB_B << st_off;
            wdata = {4{st_data[7:0]}};
         end
         LSU_H: begin
            wstrb = STRB_H << {st_off[1], 1'b0};
            wdata = {2{st_data[15:0]}};
         end
         LSU_W: begin
            wstrb = STRB_W;
            wdata = st_data;
         end
         default: begin
            wstrb = '0;
            wdata = '0;
         end
      endcase
   end

   always_comb begin
      byte_sel = rdata[7:0];
      case (ld_off)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = ld_off[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      ld_data = '0;
      case (ld_funct3)
         LSU_B:   ld_data = {{24{byte_sel[7]}}, byte_sel};
         LSU_BU:  ld_data = {24'd0, byte_sel};
         LSU_H:   ld_data = {{16{half_sel[15]}}, half_sel};
         LSU_HU:  ld_data = {16'd0, half_sel};
         LSU_W:   ld_data = rdata;
         default: ld_data = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: multi-cycle req/gnt/rvalid bus access with core stall and one-cycle done pulse.
// Build option: MISALIGN_TRAP_EN adds misalign_trap and suppresses the bus access for misaligned H/W.
module load_store_unit
   import lsu_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  lsu_valid,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [F3_WIDTH-1:0]   funct3,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] store_data,
   output logic                  lsu_stall,
   output logic                  lsu_done,
   output logic [DATA_WIDTH-1:0] load_data,
   lsu_if.master                 bus
`ifdef MISALIGN_TRAP_EN
   ,
   output logic                  misalign_trap
`endif
);

   lsu_state_e            state;
   lsu_req_t              req_q;
   logic [F3_WIDTH-1:0]   f3_q;
   logic [1:0]            off_q;

   logic                  start;
   logic                  legal;
   logic                  trap_hit;
   logic                  bypass;
   logic [1:0]            off_n;
   logic [STRB_WIDTH-1:0] st_wstrb;
   logic [DATA_WIDTH-1:0] st_wdata;
   logic [DATA_WIDTH-1:0] ld_ext;

   assign start = lsu_valid & (mem_read | mem_write);
   assign legal = f3_legal(funct3, mem_write);

`ifdef MISALIGN_TRAP_EN
   logic trap_q;
   assign trap_hit      = legal & f3_misaligned(funct3, addr[1:0]);
   assign off_n         = addr[1:0];
   assign misalign_trap = trap_q;
`else
   // Without trapping, misaligned H/W silently drop the offending low bits
   assign trap_hit = 1'b0;
   assign off_n    = f3_align(funct3, addr[1:0]);
`endif

   assign bypass = ~legal | trap_hit;

   lsu_align u_align (
      .st_funct3 (funct3),
      .st_off    (off_n),
      .st_data   (store_data),
      .wstrb     (st_wstrb),
      .wdata     (st_wdata),
      .ld_funct3 (f3_q),
      .ld_off    (off_q),
      .rdata     (bus.bus_rdata),
      .ld_data   (ld_ext)
   );

   // Access sequencer; rvalid is only honoured in WAIT so early or late data is ignored
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         req_q     <= '0;
         f3_q      <= '0;
         off_q     <= '0;
         load_data <= '0;
`ifdef MISALIGN_TRAP_EN
         trap_q    <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  req_q.addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                  req_q.we    <= mem_write;
                  req_q.wdata <= st_wdata;
                  req_q.wstrb <= st_wstrb;
                  f3_q        <= funct3;
                  off_q       <= off_n;
                  load_data   <= '0;
`ifdef MISALIGN_TRAP_EN
                  trap_q      <= trap_hit;
`endif
                  state       <= bypass ? S_DONE : S_REQ;
               end
            end
            S_REQ: begin
               if (bus.bus_gnt) begin
                  state <= req_q.we ? S_DONE : S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.bus_rvalid) begin
                  load_data <= ld_ext;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
`ifdef MISALIGN_TRAP_EN
               trap_q <= 1'b0;
`endif
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Request and stall are gated by rst so a reset drops them in the cycle it is asserted
   assign bus.bus_req   = (state == S_REQ) & ~rst;
   assign bus.bus_we    = req_q.we;
   assign bus.bus_addr  = req_q.addr;
   assign bus.bus_wdata = req_q.wdata;
   assign bus.bus_wstrb = req_q.wstrb;

   assign lsu_stall = ~rst & ((state == S_REQ) | (state == S_WAIT) | ((state == S_IDLE) & start));
   assign lsu_done  = (state == S_DONE);

endmodule
